fetch_queue: RTL

//   Parametrised, decoupled instruction-fetch stage for the next-generation core.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch stage: pipelined requests to a variable-latency imem,
// returned instructions buffered with their PCs in a DEPTH-entry FIFO for decode.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_insn,
    output logic            redirect_misal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    logic                 run_q;
    logic [XLEN-1:0]      fetch_pc;
    logic [XLEN-1:0]      rsp_pc;
    logic [CNT_W-1:0]     occupancy;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     drop_cnt;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 misal_p1;
    logic [XLEN-1:0]      pc_mem   [DEPTH];
    logic [31:0]          insn_mem [DEPTH];

    logic                 req_fire;
    logic                 rsp_fire;
    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     outstanding_nxt;

    // Credits count both queued entries and requests still in flight, so a push never overflows.
    assign imem_req_valid  = run_q
                           && (({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_C)
                           && (outstanding < MAX_OUT_C);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign rsp_fire        = imem_rsp_valid;
    assign push            = rsp_fire && (drop_cnt == '0) && !redirect_valid;
    assign pop             = dec_valid && dec_ready && !redirect_valid;
    assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    assign dec_valid       = (occupancy != '0);
    assign dec_pc          = dec_valid ? pc_mem[rd_ptr] : '0;
    assign dec_insn        = dec_valid ? insn_mem[rd_ptr] : '0;
    assign redirect_misal  = misal_p1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            misal_p1    <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_nxt;
            misal_p1    <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                // Everything still owed by memory, including this cycle's request, is stale.
                fetch_pc  <= align_pc(redirect_pc);
                rsp_pc    <= align_pc(redirect_pc);
                occupancy <= '0;
                rd_ptr    <= wr_ptr;
                drop_cnt  <= outstanding_nxt;
            end else begin
                if (req_fire)
                    fetch_pc <= pc_inc(fetch_pc);
                if (push) begin
                    rsp_pc <= pc_inc(rsp_pc);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (rsp_fire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CNT_W'(1);
                occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO payload
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            insn_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clock) disable iff (!reset) outstanding <= MAX_OUT_C);
    assert property (@(posedge clock) disable iff (!reset)
                     ({1'b0, occupancy} + {1'b0, outstanding}) <= DEPTH_C);
    assert property (@(posedge clock) disable iff (!reset) drop_cnt <= outstanding);
endmodule
